huffman_decode: RTL and testbench
=================================

Name: huffman_decode

Overview:
- Receiver-side counterpart of the symbol frequency/encode path. Accepts a serial Huffman bitstream, MSB-first per codeword, and emits decoded 4-bit symbols 0..NSYM-1.
- A per-symbol code table is loaded while idle, normally from the tree built from getnum counts.
- Also counts decoded symbols so a bench can cross-check them against the encoder-side totals.

Parameters:
- NSYM, 10, number of symbols / table entries
- MAXLEN, 9, maximum codeword length in bits
- CNTW, 9, width of the decoded-symbol counter

Ports:
- Clk_in  in  1  system clock, rising edge
- nRst  in  1  asynchronous active-low reset
- Tbl_we  in  1  table write strobe; honoured only in IDLE
- Tbl_sym  in  4  table entry index; writes with index >= NSYM are ignored
- Tbl_code  in  MAXLEN  codeword, right-aligned (bit 0 = last transmitted bit)
- Tbl_len  in  4  codeword length; 0 = entry unused; values > MAXLEN are treated as 0
- Start  in  1  one-cycle pulse: begin or restart decoding
- End  in  1  one-cycle pulse: stream finished
- Bit_in  in  1  serial code bit
- Bit_valid  in  1  Bit_in is valid this cycle
- Sym_out  out  4  decoded symbol
- Sym_valid  out  1  one-cycle pulse; Sym_out is valid
- Sym_cnt  out  CNTW  number of symbols decoded since Start, saturating
- Busy  out  1  high in DECODE
- Err  out  1  sticky decode error

Behaviour:
- Reset (nRst=0, asynchronous): state IDLE; all table lengths 0; accumulator and bit count 0; Sym_out=0, Sym_valid=0, Sym_cnt=0, Busy=0, Err=0.
- States:
  - IDLE:
    - Tbl_we writes code and length into entry Tbl_sym.
    - Start -> DECODE; clears accumulator, bit count, Sym_cnt and Err.
  - DECODE:
    - Tbl_we is ignored.
    - On Bit_valid: acc_next = {acc[MAXLEN-2:0], Bit_in}; n_next = n+1.
    - acc_next is compared with every entry whose len == n_next (low n_next bits compared).
    - On match: next cycle Sym_out = matching index and Sym_valid = 1. Accumulator and n clear in the same edge, so back-to-back bits are accepted with no gap.
    - Multiple matches (table not prefix-free): the lowest index wins.
    - No match and n_next == MAXLEN: Err=1, go to ERROR.
  - ERROR:
    - Bits are ignored and Busy=0.
    - Start -> DECODE (Err cleared).
    - End -> IDLE (Err held).
- Latency: Sym_valid asserts exactly 1 cycle after the cycle in which the final code bit has Bit_valid=1. Sym_out holds its value until the next match.
- Sym_cnt increments with each Sym_valid and saturates at 2^CNTW-1.
- End in DECODE -> IDLE.
  - If n != 0 (partial codeword pending): Err=1.
  - A bit arriving with Bit_valid in the same cycle as End is discarded; End has priority.
- Start in DECODE or ERROR has the same effect as Start from IDLE. It takes priority over Bit_valid and End in the same cycle.
- Start and Tbl_we in the same IDLE cycle: both take effect.
- Busy = (state == DECODE).
- Bit_valid in IDLE is ignored.
- An empty table (all lengths 0) produces no matches; after MAXLEN bits, Err=1.

Decomposition:
- Shared package/header: state encodings (IDLE, DECODE, ERROR), NSYM/MAXLEN/CNTW defaults, symbol-width constant (4).
- One sub-module, huffman_match:
  - Combinational compare of acc_next/n_next against all NSYM entries.
  - Outputs hit and index via a lowest-index priority encode.
- The top level holds the table registers, accumulator, FSM and counter.

Test Plan:
- Table: sym0="0"/1, sym1="10"/2, sym2="110"/3, sym3="111"/3, rest len 0. Start, then bits 0,1,0,1,1,0,1,1,1 on consecutive cycles -> Sym_valid pulses with Sym_out 0,1,2,3, each 1 cycle after that code's last bit; Sym_cnt=4; Err=0.
- Same table, bits 1,1 then End -> IDLE, Err=1, no Sym_valid, Sym_cnt=0.
- Table with only sym5="101"/3. Start, then 9 bits of 0 -> Err=1 on the 9th bit's edge, state ERROR. Further bits give no Sym_valid. Start -> Err=0, Busy=1.
- Non-prefix table sym2="1"/1, sym7="1"/1. Bit 1 -> Sym_out=2.
- Tbl_we during DECODE is ignored: prior codes still decode. Bit_valid together with End -> bit dropped, state IDLE.
- nRst pulsed low mid-codeword (after bits 1,1) -> outputs 0 immediately and table cleared. After reload and Start, decoding begins fresh with no residual bits. Saturation check: 600 codes of sym0 -> Sym_cnt=511.

Source files
------------

// File: rtl/huffman_decode_pkg.sv
// rtl/huffman_decode_pkg.sv - shared constants and state encodings for the Huffman decoder
package huffman_decode_pkg;

  localparam int NSYM_DEF   = 10;
  localparam int MAXLEN_DEF = 9;
  localparam int CNTW_DEF   = 9;
  localparam int SYMW       = 4;
  localparam int LENW       = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_ERROR  = 2'd2;

endpackage

// File: rtl/huffman_decode_if.sv
// rtl/huffman_decode_if.sv - table load, bitstream and symbol output signal bundle
interface huffman_decode_if
  import huffman_decode_pkg::*;
#(
  parameter int MAXLEN = MAXLEN_DEF,
  parameter int CNTW   = CNTW_DEF
);

  logic              Tbl_we;
  logic [SYMW-1:0]   Tbl_sym;
  logic [MAXLEN-1:0] Tbl_code;
  logic [LENW-1:0]   Tbl_len;
  logic              Start;
  logic              End;
  logic              Bit_in;
  logic              Bit_valid;
  logic [SYMW-1:0]   Sym_out;
  logic              Sym_valid;
  logic [CNTW-1:0]   Sym_cnt;
  logic              Busy;
  logic              Err;

  modport master (
    output Tbl_we, Tbl_sym, Tbl_code, Tbl_len, Start, End, Bit_in, Bit_valid,
    input  Sym_out, Sym_valid, Sym_cnt, Busy, Err
  );

  modport slave (
    input  Tbl_we, Tbl_sym, Tbl_code, Tbl_len, Start, End, Bit_in, Bit_valid,
    output Sym_out, Sym_valid, Sym_cnt, Busy, Err
  );

endinterface

// File: rtl/huffman_match.sv
// rtl/huffman_match.sv - parallel codeword compare with lowest-index priority
module huffman_match
  import huffman_decode_pkg::*;
#(
  parameter int NSYM   = NSYM_DEF,
  parameter int MAXLEN = MAXLEN_DEF
) (
  input  logic [MAXLEN-1:0]            acc_next,
  input  logic [LENW-1:0]              n_next,
  input  logic [NSYM-1:0][MAXLEN-1:0]  code,
  input  logic [NSYM-1:0][LENW-1:0]    len,
  output logic                         hit,
  output logic [SYMW-1:0]              idx
);

  logic [MAXLEN-1:0] mask;

  // Only the low n_next bits of the accumulator hold the codeword in flight
  always_comb begin
    mask = '0;
    for (int b = 0; b < MAXLEN; b++) begin
      mask[b] = (b < int'(n_next));
    end
  end

  // Scan from the top so the lowest matching index is the one left standing
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NSYM - 1; i >= 0; i--) begin
      if (len[i] == n_next && ((acc_next ^ code[i]) & mask) == '0) begin
        hit = 1'b1;
        idx = SYMW'(i);
      end
    end
  end

endmodule

// File: rtl/huffman_decode.sv
// rtl/huffman_decode.sv - serial Huffman decoder with code table, FSM and symbol counter
module huffman_decode
  import huffman_decode_pkg::*;
#(
  parameter int NSYM   = NSYM_DEF,
  parameter int MAXLEN = MAXLEN_DEF,
  parameter int CNTW   = CNTW_DEF
) (
  input  logic             Clk_in,
  input  logic             nRst,
  huffman_decode_if.slave  bus
);

  logic [1:0]                      state_q;
  logic [NSYM-1:0][MAXLEN-1:0]     code_q;
  logic [NSYM-1:0][LENW-1:0]       len_q;
  logic [MAXLEN-2:0]               acc_q;
  logic [MAXLEN-1:0]               acc_next;
  logic [LENW-1:0]                 n_q;
  logic [LENW-1:0]                 n_next;
  logic                            hit;
  logic [SYMW-1:0]                 hit_idx;
  logic [SYMW-1:0]                 sym_q;
  logic                            sym_valid_q;
  logic [CNTW-1:0]                 cnt_q;
  logic                            err_q;

  // A stored partial codeword is at most MAXLEN-1 bits, so the top bit only exists in acc_next
  assign acc_next = {acc_q, bus.Bit_in};
  assign n_next   = n_q + LENW'(1);

  huffman_match #(.NSYM(NSYM), .MAXLEN(MAXLEN)) u_match (
    .acc_next (acc_next),
    .n_next   (n_next),
    .code     (code_q),
    .len      (len_q),
    .hit      (hit),
    .idx      (hit_idx)
  );

  // Code table loads only while idle; out-of-range lengths store as unused
  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      code_q <= '0;
      len_q  <= '0;
    end else if (state_q == ST_IDLE && bus.Tbl_we && int'(bus.Tbl_sym) < NSYM) begin
      code_q[bus.Tbl_sym] <= bus.Tbl_code;
      len_q[bus.Tbl_sym]  <= (int'(bus.Tbl_len) > MAXLEN) ? '0 : bus.Tbl_len;
    end
  end

  // FSM, bit accumulator, symbol output and saturating counter; Start overrides everything
  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      n_q         <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      sym_valid_q <= 1'b0;
      if (bus.Start) begin
        state_q <= ST_DECODE;
        acc_q   <= '0;
        n_q     <= '0;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_DECODE: begin
            if (bus.End) begin
              state_q <= ST_IDLE;
              acc_q   <= '0;
              n_q     <= '0;
              if (n_q != '0) err_q <= 1'b1;
            end else if (bus.Bit_valid) begin
              if (hit) begin
                sym_q       <= hit_idx;
                sym_valid_q <= 1'b1;
                if (cnt_q != '1) cnt_q <= cnt_q + CNTW'(1);
                acc_q       <= '0;
                n_q         <= '0;
              end else if (n_next == LENW'(MAXLEN)) begin
                err_q   <= 1'b1;
                state_q <= ST_ERROR;
                acc_q   <= '0;
                n_q     <= '0;
              end else begin
                acc_q <= acc_next[MAXLEN-2:0];
                n_q   <= n_next;
              end
            end
          end
          ST_ERROR: begin
            if (bus.End) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.Sym_out   = sym_q;
  assign bus.Sym_valid = sym_valid_q;
  assign bus.Sym_cnt   = cnt_q;
  assign bus.Busy      = (state_q == ST_DECODE);
  assign bus.Err       = err_q;

endmodule

// File: tb/tb_huffman_decode.sv
// tb/tb_huffman_decode.sv - directed self-checking bench for huffman_decode
module tb_huffman_decode;
  import huffman_decode_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  huffman_decode_if bus ();

  huffman_decode dut (
    .Clk_in (clk),
    .nRst   (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int s, input logic [8:0] c, input int l);
    bus.Tbl_we   = 1'b1;
    bus.Tbl_sym  = 4'(s);
    bus.Tbl_code = c;
    bus.Tbl_len  = 4'(l);
    tick();
    bus.Tbl_we   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic pulse_end();
    bus.End = 1'b1;
    tick();
    bus.End = 1'b0;
  endtask

  task automatic send(input logic b, output logic v, output logic [3:0] s);
    bus.Bit_valid = 1'b1;
    bus.Bit_in    = b;
    tick();
    bus.Bit_valid = 1'b0;
    v = bus.Sym_valid;
    s = bus.Sym_out;
  endtask

  task automatic load_base();
    load(0, 9'b0,   1);
    load(1, 9'b10,  2);
    load(2, 9'b110, 3);
    load(3, 9'b111, 3);
  endtask

  logic       v;
  logic [3:0] s;
  logic [8:0] bits1;
  logic [8:0] vexp1;
  int         exp_sym [4];
  int         k;

  initial begin
    bus.Tbl_we = 0; bus.Tbl_sym = 0; bus.Tbl_code = 0; bus.Tbl_len = 0;
    bus.Start = 0; bus.End = 0; bus.Bit_in = 0; bus.Bit_valid = 0;
    exp_sym = '{0, 1, 2, 3};

    // reset state
    tick(); tick();
    check("rst sym_out", 32'(bus.Sym_out), 0);
    check("rst sym_valid", 32'(bus.Sym_valid), 0);
    check("rst sym_cnt", 32'(bus.Sym_cnt), 0);
    check("rst busy", 32'(bus.Busy), 0);
    check("rst err", 32'(bus.Err), 0);
    rst_n = 1'b1;

    // basic decode of 0 | 10 | 110 | 111
    load_base();
    pulse_start();
    check("t1 busy", 32'(bus.Busy), 1);
    bits1 = 9'b010110111;
    vexp1 = 9'b101001001;
    k = 0;
    for (int i = 8; i >= 0; i--) begin
      send(bits1[i], v, s);
      check($sformatf("t1 valid bit%0d", 8 - i), 32'(v), 32'(vexp1[i]));
      if (vexp1[i]) begin
        check($sformatf("t1 sym%0d", k), 32'(s), 32'(exp_sym[k]));
        k++;
      end
    end
    tick();
    check("t1 valid idle", 32'(bus.Sym_valid), 0);
    check("t1 sym hold", 32'(bus.Sym_out), 3);
    check("t1 cnt", 32'(bus.Sym_cnt), 4);
    check("t1 err", 32'(bus.Err), 0);

    // partial codeword then End
    pulse_start();
    send(1'b1, v, s); check("t2 valid a", 32'(v), 0);
    send(1'b1, v, s); check("t2 valid b", 32'(v), 0);
    pulse_end();
    check("t2 busy", 32'(bus.Busy), 0);
    check("t2 err", 32'(bus.Err), 1);
    check("t2 cnt", 32'(bus.Sym_cnt), 0);
    check("t2 valid", 32'(bus.Sym_valid), 0);

    // unmatched stream runs into MAXLEN
    load(0, 9'b0, 0); load(1, 9'b0, 0); load(2, 9'b0, 0); load(3, 9'b0, 0);
    load(5, 9'b101, 3);
    pulse_start();
    check("t3 err cleared", 32'(bus.Err), 0);
    for (int i = 1; i <= 9; i++) begin
      send(1'b0, v, s);
      check($sformatf("t3 valid%0d", i), 32'(v), 0);
      if (i == 8) check("t3 err at 8", 32'(bus.Err), 0);
    end
    check("t3 err at 9", 32'(bus.Err), 1);
    check("t3 busy", 32'(bus.Busy), 0);
    send(1'b1, v, s); check("t3 ign a", 32'(v), 0);
    send(1'b0, v, s); check("t3 ign b", 32'(v), 0);
    send(1'b1, v, s); check("t3 ign c", 32'(v), 0);
    pulse_start();
    check("t3 restart err", 32'(bus.Err), 0);
    check("t3 restart busy", 32'(bus.Busy), 1);
    pulse_end();
    check("t3 end err", 32'(bus.Err), 0);

    // overlapping codes: lowest index wins
    load(5, 9'b0, 0);
    load(2, 9'b1, 1);
    load(7, 9'b1, 1);
    pulse_start();
    send(1'b1, v, s);
    check("t4 valid", 32'(v), 1);
    check("t4 sym", 32'(s), 2);
    pulse_end();

    // table write during DECODE is ignored; bit with End is dropped
    load(7, 9'b0, 0);
    load_base();
    pulse_start();
    load(0, 9'b1, 1);
    send(1'b0, v, s);
    check("t5 valid0", 32'(v), 1);
    check("t5 sym0", 32'(s), 0);
    send(1'b1, v, s);
    send(1'b0, v, s);
    check("t5 valid1", 32'(v), 1);
    check("t5 sym1", 32'(s), 1);
    bus.Bit_valid = 1'b1; bus.Bit_in = 1'b0; bus.End = 1'b1;
    tick();
    bus.Bit_valid = 1'b0; bus.End = 1'b0;
    check("t5 end valid", 32'(bus.Sym_valid), 0);
    check("t5 end busy", 32'(bus.Busy), 0);
    check("t5 end err", 32'(bus.Err), 0);
    check("t5 cnt", 32'(bus.Sym_cnt), 2);

    // asynchronous reset mid-codeword
    pulse_start();
    send(1'b1, v, s);
    send(1'b1, v, s);
    rst_n = 1'b0;
    #2;
    check("t6 rst busy", 32'(bus.Busy), 0);
    check("t6 rst sym", 32'(bus.Sym_out), 0);
    check("t6 rst cnt", 32'(bus.Sym_cnt), 0);
    check("t6 rst err", 32'(bus.Err), 0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    send(1'b0, v, s);
    check("t6 empty tbl", 32'(v), 0);
    pulse_end();
    check("t6 end err", 32'(bus.Err), 1);
    load_base();
    pulse_start();
    send(1'b0, v, s);
    check("t6 fresh valid", 32'(v), 1);
    check("t6 fresh sym", 32'(s), 0);

    // counter saturation
    pulse_start();
    for (int i = 1; i <= 600; i++) begin
      send(1'b0, v, s);
      if (i == 511) check("t7 cnt 511", 32'(bus.Sym_cnt), 511);
    end
    tick();
    check("t7 cnt sat", 32'(bus.Sym_cnt), 511);
    check("t7 err", 32'(bus.Err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
